// File: rtl/pc_fetch.sv
// pc_fetch - instruction-fetch sequencer.
//
// Owns the program counter, presents it to an external combinational
// incrementer, fetches instruction words over a req/ack handshake and holds
// each word in a one-entry slot until decode consumes it. Redirects from
// execute reload the PC and cancel any fetch still in flight.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
// Optional feature (compile-time macro):
//   PC_FETCH_ALIGN_CHECK_EN  when defined, misaligned redirect targets are
//                            forced to word alignment and flagged on
//                            misalign_err (sticky until reset)
// Ports:
//   clock, rst_n          rising-edge clock, async active-low reset
//   pc_addr  / pc_next    current PC out, incremented PC (pc_addr+4) in
//   imem_req / imem_addr  fetch request and its address
//   imem_ack / imem_rdata memory response and instruction word
//   stall                 decode cannot accept this cycle
//   redirect_valid/_addr  branch or jump target from execute
//   inst_valid/inst/inst_pc  output slot towards decode
//   misalign_err          sticky misaligned-redirect flag
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | one cycle after reset, launches the first fetch
// FETCH     | request outstanding for imem_addr
// WAIT_SLOT | slot holds an instruction, waiting for decode to take it
// DISCARD   | request outstanding whose response is stale (redirected)

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        rst_n,
  output logic [31:0] pc_addr,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_SLOT = 2'd2,
    DISCARD   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] redir_pc;
  logic        redir_bad;

`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign redir_pc  = {redirect_addr[31:2], 2'b00};
  assign redir_bad = redirect_valid && (redirect_addr[1:0] != 2'b00);
`else
  assign redir_pc  = redirect_addr;
  assign redir_bad = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    // Every state honours a redirect, so any misaligned target is flagged.
    err_d     = err_q | redir_bad;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
        // A redirect this early simply becomes the first fetch address.
        if (redirect_valid) begin
          pc_d   = redir_pc;
          addr_d = redir_pc;
        end else begin
          addr_d = pc_q;
        end
      end

      FETCH: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (imem_ack) begin
            // Response is for the old path; restart at the target right away.
            addr_d = redir_pc;
          end else begin
            // Request must still complete; its data will be thrown away.
            state_nxt = DISCARD;
          end
        end else if (imem_ack) begin
          inst_d    = imem_rdata;
          inst_pc_d = addr_q;
          valid_d   = 1'b1;
          pc_d      = pc_next;
          state_nxt = WAIT_SLOT;
        end
      end

      WAIT_SLOT: begin
        // The slot is always occupied here, so consumption is just !stall.
        if (redirect_valid) begin
          valid_d   = 1'b0;
          pc_d      = redir_pc;
          addr_d    = redir_pc;
          state_nxt = FETCH;
        end else if (!stall) begin
          valid_d   = 1'b0;
          addr_d    = pc_q;
          state_nxt = FETCH;
        end
      end

      DISCARD: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_ack) begin
          addr_d    = redirect_valid ? redir_pc : pc_q;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign pc_addr      = pc_q;
  assign imem_req     = (state == FETCH) || (state == DISCARD);
  assign imem_addr    = addr_q;
  assign inst_valid   = valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch. A second instance with RESET_PC=32'hFFFF_FFFC runs
// in lockstep on the same inputs to exercise PC wrap. The memory model answers
// every request after mem_wait wait cycles with data = address + 32'h13.
module tb_pc_fetch;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_addr, pc_next, imem_addr, inst, inst_pc;
  logic        imem_req, inst_valid, misalign_err;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;

  logic [31:0] w_pc_addr, w_pc_next, w_imem_addr, w_inst, w_inst_pc;
  logic        w_imem_req, w_inst_valid, w_misalign_err;

  int passed = 0;
  int total  = 0;
  int mem_wait = 0;
  int mem_cnt  = -1;

  always #5 clock = ~clock;

  assign pc_next   = pc_addr + 32'd4;
  assign w_pc_next = w_pc_addr + 32'd4;

  pc_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock(clock), .rst_n(rst_n), .pc_addr(pc_addr), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .misalign_err(misalign_err)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .rst_n(rst_n), .pc_addr(w_pc_addr), .pc_next(w_pc_next),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .inst_valid(w_inst_valid), .inst(w_inst),
    .inst_pc(w_inst_pc), .misalign_err(w_misalign_err)
  );

  // Memory: mem_cnt counts cycles of the current request; a new request
  // starts on the first req cycle and on any req cycle right after an ack.
  always @(negedge clock) begin
    if (!rst_n || !imem_req) begin
      mem_cnt    = -1;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
    end else begin
      if (imem_ack || mem_cnt < 0) mem_cnt = 0;
      else                         mem_cnt = mem_cnt + 1;
      imem_ack   = (mem_cnt == mem_wait);
      imem_rdata = imem_ack ? (imem_addr + 32'h13) : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Returns at the first negedge after reset release (state FETCH).
  task automatic do_reset(input int wt, input bit chk_rst);
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    mem_wait       = wt;
    repeat (2) step();
    if (chk_rst) begin
      chk("rst_pc",      pc_addr,      32'h0);
      chk("rst_req",     {31'h0, imem_req},   32'h0);
      chk("rst_addr",    imem_addr,    32'h0);
      chk("rst_valid",   {31'h0, inst_valid}, 32'h0);
      chk("rst_inst",    inst,         32'h0);
      chk("rst_ipc",     inst_pc,      32'h0);
      chk("rst_err",     {31'h0, misalign_err}, 32'h0);
      chk("rst_wrap_pc", w_pc_addr,    32'hFFFF_FFFC);
    end
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] ra;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        wchk;
    logic [31:0] waddr;
  } vec_t;

  vec_t vt[13];
  logic [31:0] exp_mis_addr;
  logic        exp_mis_err;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         st  rv  ra          req addr        vld inst        ipc        wchk waddr
    vt[0]  = '{0, 0, 32'h0,   1, 32'h0,    0, 32'h0,    32'h0,    1, 32'hFFFF_FFFC};
    vt[1]  = '{1, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[2]  = '{1, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[3]  = '{1, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[4]  = '{1, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[5]  = '{1, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[6]  = '{0, 0, 32'h0,   0, 32'h0,    1, 32'h13,   32'h0,    0, 32'h0};
    vt[7]  = '{0, 0, 32'h0,   1, 32'h4,    0, 32'h0,    32'h0,    1, 32'h0};
    vt[8]  = '{1, 1, 32'h40,  0, 32'h4,    1, 32'h17,   32'h4,    0, 32'h0};
    vt[9]  = '{0, 0, 32'h0,   1, 32'h40,   0, 32'h0,    32'h0,    0, 32'h0};
    vt[10] = '{0, 0, 32'h0,   0, 32'h40,   1, 32'h53,   32'h40,   0, 32'h0};
    vt[11] = '{0, 0, 32'h0,   1, 32'h44,   0, 32'h0,    32'h0,    0, 32'h0};
    vt[12] = '{0, 0, 32'h0,   0, 32'h44,   1, 32'h57,   32'h44,   0, 32'h0};

    // Zero-wait fetch, stall hold, redirect with occupied slot, wrap.
    do_reset(0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d_req", i),   {31'h0, imem_req},   {31'h0, vt[i].req});
      chk($sformatf("v%0d_addr", i),  imem_addr,           vt[i].addr);
      chk($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, vt[i].valid});
      if (vt[i].valid) begin
        chk($sformatf("v%0d_inst", i), inst,    vt[i].inst);
        chk($sformatf("v%0d_ipc", i),  inst_pc, vt[i].ipc);
      end
      if (vt[i].wchk) chk($sformatf("v%0d_wrap_addr", i), w_imem_addr, vt[i].waddr);
      stall          = vt[i].st;
      redirect_valid = vt[i].rv;
      redirect_addr  = vt[i].ra;
      step();
    end

    // Redirect in the first cycle of a 3-wait fetch.
    do_reset(3, 1'b0);
    chk("rw_req0",  {31'h0, imem_req}, 32'h1);
    chk("rw_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("rw_disc_req",  {31'h0, imem_req}, 32'h1);
    chk("rw_disc_addr", imem_addr, 32'h0);
    chk("rw_disc_pc",   pc_addr,   32'h100);
    step();
    chk("rw_disc_valid1", {31'h0, inst_valid}, 32'h0);
    step();
    chk("rw_disc_valid2", {31'h0, inst_valid}, 32'h0);
    step();
    chk("rw_refetch_req",   {31'h0, imem_req}, 32'h1);
    chk("rw_refetch_addr",  imem_addr, 32'h100);
    chk("rw_refetch_valid", {31'h0, inst_valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rw_wait%0d_valid", k), {31'h0, inst_valid}, 32'h0);
    end
    step();
    chk("rw_valid", {31'h0, inst_valid}, 32'h1);
    chk("rw_inst",  inst,    32'h113);
    chk("rw_ipc",   inst_pc, 32'h100);

    // Redirect and ack in the same FETCH cycle.
    do_reset(0, 1'b0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("ra_req",   {31'h0, imem_req}, 32'h1);
    chk("ra_addr",  imem_addr, 32'h200);
    chk("ra_valid", {31'h0, inst_valid}, 32'h0);
    step();
    chk("ra_inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("ra_inst",       inst,    32'h213);
    chk("ra_ipc",        inst_pc, 32'h200);

    // DISCARD: redirect alone, then redirect together with the ack.
    do_reset(2, 1'b0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h300;
    step();
    chk("dr_pc1",   pc_addr,   32'h300);
    chk("dr_addr1", imem_addr, 32'h0);
    redirect_addr = 32'h304;
    step();
    chk("dr_pc2",   pc_addr,   32'h304);
    chk("dr_req2",  {31'h0, imem_req}, 32'h1);
    chk("dr_addr2", imem_addr, 32'h0);
    redirect_addr = 32'h308;
    step();
    redirect_valid = 1'b0;
    chk("dr_req3",  {31'h0, imem_req}, 32'h1);
    chk("dr_addr3", imem_addr, 32'h308);
    chk("dr_pc3",   pc_addr,   32'h308);

    // Misaligned redirect, then asynchronous reset mid-fetch.
`ifdef PC_FETCH_ALIGN_CHECK_EN
    exp_mis_addr = 32'h100;
    exp_mis_err  = 1'b1;
`else
    exp_mis_addr = 32'h102;
    exp_mis_err  = 1'b0;
`endif
    do_reset(0, 1'b0);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("mis_addr", imem_addr, exp_mis_addr);
    chk("mis_err1", {31'h0, misalign_err}, {31'h0, exp_mis_err});
    step();
    chk("mis_valid", {31'h0, inst_valid}, 32'h1);
    chk("mis_ipc",   inst_pc, exp_mis_addr);
    chk("mis_err2",  {31'h0, misalign_err}, {31'h0, exp_mis_err});
    step();
    chk("mis_req",   {31'h0, imem_req}, 32'h1);
    chk("mis_addr2", imem_addr, exp_mis_addr + 32'd4);
    chk("mis_err3",  {31'h0, misalign_err}, {31'h0, exp_mis_err});
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'h0, imem_req}, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_pc",    pc_addr,   32'h0);
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_ipc",   inst_pc,   32'h0);
    chk("arst_err",   {31'h0, misalign_err}, 32'h0);

    repeat (2) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
